// File: rtl/beat_tempo_estimator.sv
// Beat tempo estimator: accepts direction-change edges as beats, measures inter-beat period, times out idle runs.
// Define TEMPO_AVG_EN to report a 4-interval running average instead of the latest interval.
module beat_tempo_estimator #(
  parameter int CNT_W        = 27,
  parameter int MIN_INTERVAL = 5_000_000,
  parameter int MAX_INTERVAL = 100_000_000
) (
  input  logic             clk_camera_in,
  input  logic             rst_in,
  input  logic             change_in,
  output logic             beat_out,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid_out,
  output logic             timeout_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTERVAL);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             change_q;
  logic             edge_det;
  logic             beat_nxt;
  logic             timeout_nxt;
  logic             accept;

  assign edge_det = change_in & ~change_q;

  // A timeout and an edge in the same cycle restart the run as a first beat.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    beat_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (edge_det) begin
          state_nxt = RUN;
          cnt_nxt   = ONE;
          beat_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (cnt >= MAX_C) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          if (edge_det) begin
            state_nxt = RUN;
            cnt_nxt   = ONE;
            beat_nxt  = 1'b1;
          end
        end else if (edge_det && (cnt >= MIN_C)) begin
          accept   = 1'b1;
          beat_nxt = 1'b1;
          cnt_nxt  = ONE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      change_q    <= 1'b0;
      beat_out    <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      change_q    <= change_in;
      beat_out    <= beat_nxt;
      timeout_out <= timeout_nxt;
    end
  end

`ifdef TEMPO_AVG_EN
  logic [3:0][CNT_W-1:0] hist;
  logic [CNT_W+1:0]      sum;
  logic [2:0]            fill;

  // Sum is maintained incrementally; hist[3] is the oldest entry (zero until filled).
  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      hist <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (timeout_nxt) begin
      hist <= '0;
      sum  <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= {hist[2:0], cnt};
      sum  <= sum + {2'b00, cnt} - {2'b00, hist[3]};
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      period_out       <= '0;
      period_valid_out <= 1'b0;
    end else begin
      period_valid_out <= timeout_nxt ? 1'b0 : (fill == 3'd4);
      if (fill == 3'd4) period_out <= sum[CNT_W+1:2];
    end
  end
`else
  logic             acc_q;
  logic [CNT_W-1:0] last_q;

  always_ff @(posedge clk_camera_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q            <= 1'b0;
      last_q           <= '0;
      period_out       <= '0;
      period_valid_out <= 1'b0;
    end else begin
      acc_q <= accept;
      if (accept) last_q <= cnt;
      if (timeout_nxt) begin
        period_valid_out <= 1'b0;
      end else if (acc_q) begin
        period_out       <= last_q;
        period_valid_out <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_beat_tempo_estimator.sv
// Scoreboard bench for beat_tempo_estimator (CNT_W=8, MIN=10, MAX=100); expectations follow TEMPO_AVG_EN.
module tb_beat_tempo_estimator;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       change_in = 1'b0;
  logic       beat_out;
  logic [7:0] period_out;
  logic       period_valid_out;
  logic       timeout_out;

  typedef struct {
    logic       b;
    logic       t;
    logic [7:0] per;
    logic       vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ref_cyc = 0;
  logic got_b, got_t;

  beat_tempo_estimator #(.CNT_W(8), .MIN_INTERVAL(10), .MAX_INTERVAL(100)) dut (
    .clk_camera_in   (clk),
    .rst_in          (rst_in),
    .change_in       (change_in),
    .beat_out        (beat_out),
    .period_out      (period_out),
    .period_valid_out(period_valid_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // pa/va: averaged build, pr/vr: latest-interval build
  task automatic expect_ev(input logic b, input logic t, input int pa, input logic va,
                           input int pr, input logic vr);
    exp_t x;
    x.b = b;
    x.t = t;
`ifdef TEMPO_AVG_EN
    x.per = 8'(pa);
    x.vld = va;
`else
    x.per = 8'(pr);
    x.vld = vr;
`endif
    exp_q.push_back(x);
  endtask

  // Raise change_in so the edge is sampled d cycles after ref_cyc.
  task automatic edge_after(input int d, input int hold, input bit upd);
    int target = ref_cyc + d;
    while (cyc < target - 1) begin
      @(posedge clk);
      #1;
    end
    change_in = 1'b1;
    @(posedge clk);
    #1;
    if (upd) ref_cyc = cyc;
    repeat (hold - 1) begin
      @(posedge clk);
      #1;
    end
    change_in = 1'b0;
  endtask

  // Monitor: on a pulse, compare its kind, then the period/valid one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (beat_out || timeout_out) begin
        got_b = beat_out;
        got_t = timeout_out;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got beat=%0d timeout=%0d, expected none (cycle %0d)",
                   got_b, got_t, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("beat_out", int'(got_b), int'(e.b));
          chk("timeout_out", int'(got_t), int'(e.t));
          chk("period_out", int'(period_out), int'(e.per));
          chk("period_valid_out", int'(period_valid_out), int'(e.vld));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_beat", int'(beat_out), 0);
    chk("rst_timeout", int'(timeout_out), 0);
    chk("rst_period", int'(period_out), 0);
    chk("rst_valid", int'(period_valid_out), 0);
    @(posedge clk);
    #1 rst_in = 1'b0;
    ref_cyc = cyc;

    // Steady 20-cycle beats, then a varying tempo.
    expect_ev(1, 0, 0, 0, 0, 0);   edge_after(3, 1, 1);
    expect_ev(1, 0, 0, 0, 20, 1);  edge_after(20, 1, 1);
    expect_ev(1, 0, 0, 0, 20, 1);  edge_after(20, 1, 1);
    expect_ev(1, 0, 0, 0, 20, 1);  edge_after(20, 1, 1);
    expect_ev(1, 0, 20, 1, 20, 1); edge_after(20, 1, 1);
    expect_ev(1, 0, 21, 1, 24, 1); edge_after(24, 1, 1);
    expect_ev(1, 0, 23, 1, 28, 1); edge_after(28, 1, 1);
    expect_ev(1, 0, 25, 1, 31, 1); edge_after(31, 1, 1);
    expect_ev(1, 0, 30, 1, 40, 1); edge_after(40, 1, 1);

    // Too-close edge held 3 cycles is ignored; counter keeps running.
    edge_after(5, 3, 0);
    expect_ev(1, 0, 29, 1, 20, 1); edge_after(20, 1, 1);

    // Timeout with no edge, then a fresh first beat.
    expect_ev(0, 1, 29, 0, 20, 0);
    expect_ev(1, 0, 29, 0, 20, 0); edge_after(115, 1, 1);

    // Edge coincident with counter = MAX.
    expect_ev(1, 1, 29, 0, 20, 0); edge_after(100, 1, 1);
    expect_ev(1, 0, 29, 0, 15, 1); edge_after(15, 1, 1);

    // 9 rejected, 10 (MIN) accepted, truncating average, 99 accepted.
    edge_after(9, 1, 0);
    expect_ev(1, 0, 29, 0, 12, 1); edge_after(12, 1, 1);
    expect_ev(1, 0, 29, 0, 10, 1); edge_after(10, 1, 1);
    expect_ev(1, 0, 13, 1, 17, 1); edge_after(17, 1, 1);
    expect_ev(1, 0, 34, 1, 99, 1); edge_after(99, 1, 1);

    // Asynchronous reset between clock edges with change_in held high.
    repeat (5) @(posedge clk);
    #3;
    rst_in = 1'b1;
    change_in = 1'b1;
    #1;
    chk("midrst_beat", int'(beat_out), 0);
    chk("midrst_timeout", int'(timeout_out), 0);
    chk("midrst_period", int'(period_out), 0);
    chk("midrst_valid", int'(period_valid_out), 0);
    @(posedge clk);
    #1;
    expect_ev(1, 0, 0, 0, 0, 0);
    rst_in = 1'b0;
    @(posedge clk);
    #1;
    ref_cyc = cyc;
    change_in = 1'b0;
    expect_ev(1, 0, 0, 0, 20, 1); edge_after(20, 1, 1);

    repeat (30) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
